// File: rtl/csr_timer_bank.sv
// Multi-channel machine timer: 64-bit prescaled counter, NUM_CMP compare channels
// (one-shot or periodic), sticky W1C pending bits and a registered interrupt request.
module csr_timer_bank #(
  parameter int unsigned NUM_CMP = 4,
  parameter int unsigned PRESC_W = 8,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_we_i,
  input  logic                csr_re_i,
  input  logic [ADDR_W-1:0]   csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  output logic [31:0]         csr_rdata_o,
  output logic [NUM_CMP-1:0]  irq_vec_o,
  output logic                irq_o
);

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_TIME_LO = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_TIME_HI = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_PEND    = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_IE      = ADDR_W'(8'h04);

  function automatic logic [ADDR_W-1:0] cmp_lo_addr(input int unsigned k);
    return ADDR_W'(32'h10 + 2 * k);
  endfunction

  function automatic logic [ADDR_W-1:0] cmp_hi_addr(input int unsigned k);
    return ADDR_W'(32'h11 + 2 * k);
  endfunction

  function automatic logic [ADDR_W-1:0] mode_addr(input int unsigned k);
    return ADDR_W'(32'h20 + k);
  endfunction

  function automatic logic [ADDR_W-1:0] period_addr(input int unsigned k);
    return ADDR_W'(32'h30 + k);
  endfunction

  logic                cnt_en_q, cnt_en_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
  logic [63:0]         time_q, time_d;
  logic [31:0]         hi_shadow_q, hi_shadow_d;
  logic [NUM_CMP-1:0]  pend_q, pend_d;
  logic [NUM_CMP-1:0]  ie_q, ie_d;
  logic [NUM_CMP-1:0]  periodic_q, periodic_d;
  logic [NUM_CMP-1:0]  armed_q, armed_d;
  logic [NUM_CMP-1:0]  match;
  logic [NUM_CMP-1:0]  irq_vec_d;
  logic                irq_d;
  logic [63:0]         cmp_q [NUM_CMP];
  logic [63:0]         cmp_d [NUM_CMP];
  logic [31:0]         period_q [NUM_CMP];
  logic [31:0]         period_d [NUM_CMP];
  logic                tick;
  logic                wr_ctrl, wr_lo, wr_hi, wr_pend, wr_ie, clr;

  assign wr_ctrl = csr_we_i && (csr_addr_i == A_CTRL);
  assign wr_lo   = csr_we_i && (csr_addr_i == A_TIME_LO);
  assign wr_hi   = csr_we_i && (csr_addr_i == A_TIME_HI);
  assign wr_pend = csr_we_i && (csr_addr_i == A_PEND);
  assign wr_ie   = csr_we_i && (csr_addr_i == A_IE);
  assign clr     = wr_ctrl && csr_wdata_i[1];

  // Prescaler, counter and HI snapshot; clear beats SW half-writes, which beat the tick
  always_comb begin
    cnt_en_d    = cnt_en_q;
    presc_d     = presc_q;
    pcnt_d      = pcnt_q;
    time_d      = time_q;
    hi_shadow_d = hi_shadow_q;
    tick        = cnt_en_q && (pcnt_q == presc_q);

    if (cnt_en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    end
    if (tick) begin
      time_d = time_q + 64'd1;
    end
    if (wr_lo) begin
      time_d = {time_q[63:32], csr_wdata_i};
    end
    if (wr_hi) begin
      time_d = {csr_wdata_i, time_q[31:0]};
    end
    if (wr_ctrl) begin
      cnt_en_d = csr_wdata_i[0];
      presc_d  = csr_wdata_i[8 +: PRESC_W];
    end
    if (clr) begin
      time_d = '0;
      pcnt_d = '0;
    end
    if (csr_re_i && (csr_addr_i == A_TIME_LO)) begin
      hi_shadow_d = time_q[63:32];
    end
  end

  // Compare channels: hardware reload/disarm first, SW writes override
  always_comb begin
    periodic_d = periodic_q;
    armed_d    = armed_q;
    match      = '0;
    ie_d       = wr_ie ? csr_wdata_i[NUM_CMP-1:0] : ie_q;
    for (int unsigned k = 0; k < NUM_CMP; k++) begin
      cmp_d[k]    = cmp_q[k];
      period_d[k] = period_q[k];
      match[k]    = armed_q[k] && (time_q >= cmp_q[k]);
      if (match[k]) begin
        if (periodic_q[k]) begin
          cmp_d[k] = cmp_q[k] + {32'd0, period_q[k]};
        end else begin
          armed_d[k] = 1'b0;
        end
      end
      if (csr_we_i && (csr_addr_i == cmp_lo_addr(k))) begin
        cmp_d[k] = {cmp_q[k][63:32], csr_wdata_i};
      end
      if (csr_we_i && (csr_addr_i == cmp_hi_addr(k))) begin
        cmp_d[k] = {csr_wdata_i, cmp_q[k][31:0]};
      end
      if (csr_we_i && (csr_addr_i == mode_addr(k))) begin
        periodic_d[k] = csr_wdata_i[0];
        armed_d[k]    = csr_wdata_i[1];
      end
      if (csr_we_i && (csr_addr_i == period_addr(k))) begin
        period_d[k] = csr_wdata_i;
      end
    end
    // A match in the same cycle wins over the W1C
    pend_d    = (pend_q & ~(wr_pend ? csr_wdata_i[NUM_CMP-1:0] : '0)) | match;
    irq_vec_d = pend_q & ie_q;
    irq_d     = |irq_vec_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_en_q    <= 1'b0;
      presc_q     <= '0;
      pcnt_q      <= '0;
      time_q      <= '0;
      hi_shadow_q <= '0;
      pend_q      <= '0;
      ie_q        <= '0;
      periodic_q  <= '0;
      armed_q     <= '0;
      irq_vec_o   <= '0;
      irq_o       <= 1'b0;
      for (int unsigned k = 0; k < NUM_CMP; k++) begin
        cmp_q[k]    <= '1;
        period_q[k] <= '0;
      end
    end else begin
      cnt_en_q    <= cnt_en_d;
      presc_q     <= presc_d;
      pcnt_q      <= pcnt_d;
      time_q      <= time_d;
      hi_shadow_q <= hi_shadow_d;
      pend_q      <= pend_d;
      ie_q        <= ie_d;
      periodic_q  <= periodic_d;
      armed_q     <= armed_d;
      irq_vec_o   <= irq_vec_d;
      irq_o       <= irq_d;
      for (int unsigned k = 0; k < NUM_CMP; k++) begin
        cmp_q[k]    <= cmp_d[k];
        period_q[k] <= period_d[k];
      end
    end
  end

  // Combinational read mux; unmapped offsets return 0
  always_comb begin
    csr_rdata_o = '0;
    if (csr_addr_i == A_CTRL) begin
      csr_rdata_o[0]            = cnt_en_q;
      csr_rdata_o[8 +: PRESC_W] = presc_q;
    end
    if (csr_addr_i == A_TIME_LO) csr_rdata_o = time_q[31:0];
    if (csr_addr_i == A_TIME_HI) csr_rdata_o = hi_shadow_q;
    if (csr_addr_i == A_PEND)    csr_rdata_o = 32'(pend_q);
    if (csr_addr_i == A_IE)      csr_rdata_o = 32'(ie_q);
    for (int unsigned k = 0; k < NUM_CMP; k++) begin
      if (csr_addr_i == cmp_lo_addr(k)) csr_rdata_o = cmp_q[k][31:0];
      if (csr_addr_i == cmp_hi_addr(k)) csr_rdata_o = cmp_q[k][63:32];
      if (csr_addr_i == mode_addr(k))   csr_rdata_o = {30'd0, armed_q[k], periodic_q[k]};
      if (csr_addr_i == period_addr(k)) csr_rdata_o = period_q[k];
    end
  end

endmodule
